hack_cpu_mc: RTL and testbench
==============================

// Module: hack_cpu_mc
// PURPOSE
//  Parametrised multi-cycle successor to the single-cycle Hack-style CPU core: same A/D/M register model and C-instruction ALU.
//  Separate instruction and data memory ports with req/ack handshakes, so slow RAM/ROM inserts wait states.
//  Data width and address width are parameters. Sits between program ROM and data RAM/IO bus.
// PARAMETERS
//  DATA_W    16  data/instruction width; A, D, ALU all DATA_W bits
//  ADDR_W    15  instruction/data address width, ADDR_W <= DATA_W-1
//  RESET_PC  0   PC value loaded on reset
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  imem_req    out  1       instruction fetch request
//  imem_addr   out  ADDR_W  fetch address (= pc)
//  imem_rdata  in   DATA_W  instruction word, valid with imem_ack
//  imem_ack    in   1       fetch complete
//  dmem_req    out  1       data access request
//  dmem_we     out  1       1 = write, 0 = read; valid while dmem_req=1
//  dmem_addr   out  ADDR_W  data address
//  dmem_wdata  out  DATA_W  write data
//  dmem_rdata  in   DATA_W  read data, valid with dmem_ack
//  dmem_ack    in   1       data access complete
//  pc          out  ADDR_W  current program counter
//  halted      out  1       halt detected (CPU_HALT_EN only; else tied 0)
// BEHAVIOUR
//  Encoding: IR[DATA_W-1]=0 -> A-instr, A <= {0, IR[DATA_W-2:0]}. Else C-instr, fields from LSB:
//   j[2:0] (bit2 lt, bit1 eq, bit0 gt), d[5:3] (bit5 A, bit4 D, bit3 M), c[11:6] zx nx zy ny f no, a = bit12.
//  ALU: x=D, y=a?M:A; zx/zy zero, nx/ny invert, f ? x+y (mod 2^DATA_W) : x&y, no inverts; zr = out==0, ng = out MSB.
//  Jump taken if (j2&ng)|(j1&zr)|(j0&~zr&~ng); target = A low ADDR_W bits (value before this instr). Else pc+1, wraps.
//  FSM states: FETCH, DECODE, MREAD, EXEC, MWRITE (+HALT with macro).
//   FETCH: imem_req=1, imem_addr=pc; on imem_ack latch IR -> DECODE.
//   DECODE: A-instr: load A, pc+1 -> FETCH. C-instr: a=1 -> MREAD, else -> EXEC.
//   MREAD: dmem_req=1, we=0, addr=A; on dmem_ack latch M -> EXEC.
//   EXEC: compute ALU; write A/D per d; update pc; d[3]=1 -> MWRITE (addr = old A, wdata = ALU out, latched), else -> FETCH.
//   MWRITE: dmem_req=1, we=1; on dmem_ack -> FETCH.
//  Handshake: req and addr/we/wdata held stable until ack sampled high; ack without req ignored; ack in same cycle as req accepted.
//  Cycles with zero-wait memory: A-instr 2; C no M 3; C reading M 4; C writing M 4; read+write 5. Each wait cycle adds 1.
//  Simultaneous A and M dest: M written at old A; A updated in EXEC.
//  Reset: pc=RESET_PC, A=0, D=0, IR=0, state FETCH, imem_req=0 and dmem_req=0 during reset cycle, halted=0.
//  Reset mid-transaction: transaction abandoned, no register/PC update; first FETCH request the cycle after reset deasserts.
// CONFIGURATION
//  CPU_HALT_EN defined: in EXEC, unconditional jump (j=111) with target == current pc -> HALT state; no further requests,
//   pc frozen, halted=1 until reset. Pending M write in that instruction still completes before HALT.
//  CPU_HALT_EN undefined: no HALT state, self-jump loops fetching forever, halted tied 0.
// TESTING
//  1 Reset, 0-wait mem, ROM {0x0005, 0xEC10 (D=A)} -> after 5 cycles D=5, pc=2, no dmem_req.
//  2 A=0x0010, C-instr M=D+1 with D=7 -> one write, dmem_addr=0x0010, wdata=8, we=1; pc advances by 1.
//  3 Read M (D=M) with dmem_ack delayed 3 cycles -> req/addr held stable 4 cycles, D = rdata, no early update.
//  4 D=0, A=0x0020, D;JEQ -> pc=0x0020; same with D=1 -> pc=pc+1; D=0xFFFF with JLT -> taken.
//  5 AM=M+1 with A=0x0030, M=4 -> write addr 0x0030 data 5, then A=5; assert reset during MWRITE wait -> no write ack effect, pc=RESET_PC.
//  6 CPU_HALT_EN: at pc=0x0004, A=0x0004, 0;JMP -> halted=1, req stay 0 for 20 cycles; undefined build: repeated fetch at 0x0004.

Source files
------------

// File: rtl/hack_cpu_mc.sv
// hack_cpu_mc: multi-cycle Hack-style CPU (A/D/M registers, C-instruction ALU) with req/ack imem and dmem ports.
// Latency: A-instr 2 cycles, C-instr 3 (no M), 4 (M read or M write), 5 (both); each memory wait cycle adds 1.
// Backpressure: a memory request holds req/addr/we/wdata stable until ack is sampled high; ack without req is ignored.
// Option: define CPU_HALT_EN to stop in a HALT state on an unconditional self-jump (halted=1 until reset).
module hack_cpu_mc #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 15,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
);

`ifdef CPU_HALT_EN
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE, S_HALT} state_t;
`else
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_MREAD, S_EXEC, S_MWRITE} state_t;
`endif

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [DATA_W-1:0]   r_a;
  logic [DATA_W-1:0]   r_d;
  logic [DATA_W-1:0]   r_m;
  logic [DATA_W-1:0]   r_ir;
  logic                r_dmem_we;
  logic [ADDR_W-1:0]   r_dmem_addr;
  logic [DATA_W-1:0]   r_dmem_wdata;
`ifdef CPU_HALT_EN
  logic                r_halt_pend;
  logic                w_self_halt;
`endif

  // Instruction fields
  logic                w_is_c;
  logic                w_sel_m;
  logic                w_zx, w_nx, w_zy, w_ny, w_f, w_no;
  logic                w_dst_a, w_dst_d, w_dst_m;
  logic [2:0]          w_jmp_bits;

  assign w_is_c     = r_ir[DATA_W-1];
  assign w_sel_m    = r_ir[12];
  assign w_zx       = r_ir[11];
  assign w_nx       = r_ir[10];
  assign w_zy       = r_ir[9];
  assign w_ny       = r_ir[8];
  assign w_f        = r_ir[7];
  assign w_no       = r_ir[6];
  assign w_dst_a    = r_ir[5];
  assign w_dst_d    = r_ir[4];
  assign w_dst_m    = r_ir[3];
  assign w_jmp_bits = r_ir[2:0];

  // ALU datapath and jump decision
  logic [DATA_W-1:0]   w_x, w_y, w_fout, w_alu;
  logic                w_zr, w_ng, w_jmp;
  logic [ADDR_W-1:0]   w_pc_inc, w_target, w_next_pc;

  // Combinational ALU: x is D, y is A or M; jump on lt/eq/gt flags of the result
  always_comb begin
    w_x = r_d;
    w_y = w_sel_m ? r_m : r_a;
    if (w_zx) w_x = '0;
    if (w_nx) w_x = ~w_x;
    if (w_zy) w_y = '0;
    if (w_ny) w_y = ~w_y;
    w_fout = w_f ? (w_x + w_y) : (w_x & w_y);
    w_alu  = w_no ? ~w_fout : w_fout;
    w_zr   = (w_alu == '0);
    w_ng   = w_alu[DATA_W-1];
    w_jmp  = (w_jmp_bits[2] & w_ng) | (w_jmp_bits[1] & w_zr) | (w_jmp_bits[0] & ~w_zr & ~w_ng);
  end

  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_target  = r_a[ADDR_W-1:0];
  assign w_next_pc = w_jmp ? w_target : w_pc_inc;
`ifdef CPU_HALT_EN
  assign w_self_halt = (w_jmp_bits == 3'b111) && (w_target == r_pc);
`endif

  // Requests follow the state but are forced low in any cycle reset is asserted
  assign imem_req   = (r_state == S_FETCH) && !reset;
  assign imem_addr  = r_pc;
  assign dmem_req   = ((r_state == S_MREAD) || (r_state == S_MWRITE)) && !reset;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;
  assign pc         = r_pc;
`ifdef CPU_HALT_EN
  assign halted     = (r_state == S_HALT);
`else
  assign halted     = 1'b0;
`endif

  // Control FSM plus architectural state; reset abandons any transaction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_FETCH;
      r_pc         <= ADDR_W'(RESET_PC);
      r_a          <= '0;
      r_d          <= '0;
      r_m          <= '0;
      r_ir         <= '0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
`ifdef CPU_HALT_EN
      r_halt_pend  <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ack) begin
            r_ir    <= imem_rdata;
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (!w_is_c) begin
            r_a     <= {1'b0, r_ir[DATA_W-2:0]};
            r_pc    <= w_pc_inc;
            r_state <= S_FETCH;
          end else if (w_sel_m) begin
            r_dmem_addr <= r_a[ADDR_W-1:0];
            r_dmem_we   <= 1'b0;
            r_state     <= S_MREAD;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_MREAD: begin
          if (dmem_ack) begin
            r_m     <= dmem_rdata;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_dst_a) r_a <= w_alu;
          if (w_dst_d) r_d <= w_alu;
          r_pc <= w_next_pc;
`ifdef CPU_HALT_EN
          r_halt_pend <= w_self_halt;
`endif
          if (w_dst_m) begin
            // M is written at the A value that was current when this instruction started
            r_dmem_addr  <= r_a[ADDR_W-1:0];
            r_dmem_wdata <= w_alu;
            r_dmem_we    <= 1'b1;
            r_state      <= S_MWRITE;
          end else begin
`ifdef CPU_HALT_EN
            r_state <= w_self_halt ? S_HALT : S_FETCH;
`else
            r_state <= S_FETCH;
`endif
          end
        end
        S_MWRITE: begin
          if (dmem_ack) begin
            r_dmem_we <= 1'b0;
`ifdef CPU_HALT_EN
            r_state   <= r_halt_pend ? S_HALT : S_FETCH;
`else
            r_state   <= S_FETCH;
`endif
          end
        end
`ifdef CPU_HALT_EN
        S_HALT: begin
          r_state <= S_HALT;
        end
`endif
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hack_cpu_mc.sv
// tb_hack_cpu_mc: directed programs for hack_cpu_mc against a ROM/RAM responder with programmable wait states.
// Expected values are hand-computed from the instruction encodings in each program.
`timescale 1ns/1ps
module tb_hack_cpu_mc;
  localparam int DW = 16;
  localparam int AW = 15;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_rdata;
  logic          imem_ack;
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [DW-1:0] dmem_wdata;
  logic [DW-1:0] dmem_rdata;
  logic          dmem_ack;
  logic [AW-1:0] pc;
  logic          halted;

  logic [DW-1:0] rom [0:255];
  logic [DW-1:0] ram [0:255];
  int i_wait = 0, d_rd_wait = 0, d_wr_wait = 0;
  int i_cnt = 0, d_cnt = 0;
  int n_fetch = 0, n_wr = 0, n_ireq = 0, n_dreq = 0;
  logic [AW-1:0] last_waddr = '0;
  logic [DW-1:0] last_wdata = '0;
  int n_cmp = 0, n_bad = 0;
  int base_a, base_b;

  always #5 clk = ~clk;

  hack_cpu_mc dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .dmem_ack   (dmem_ack),
    .pc         (pc),
    .halted     (halted)
  );

  // Memory responder: ack once the request has waited the configured number of cycles
  assign imem_rdata = rom[imem_addr[7:0]];
  assign dmem_rdata = ram[dmem_addr[7:0]];
  assign imem_ack   = imem_req && (i_cnt >= i_wait);
  assign dmem_ack   = dmem_req && (d_cnt >= (dmem_we ? d_wr_wait : d_rd_wait));

  always @(posedge clk) begin
    if (imem_req && !imem_ack) i_cnt <= i_cnt + 1; else i_cnt <= 0;
    if (dmem_req && !dmem_ack) d_cnt <= d_cnt + 1; else d_cnt <= 0;
    if (imem_req) n_ireq <= n_ireq + 1;
    if (imem_req && imem_ack) n_fetch <= n_fetch + 1;
    if (dmem_req) n_dreq <= n_dreq + 1;
    if (dmem_req && dmem_ack && dmem_we) begin
      n_wr       <= n_wr + 1;
      last_waddr <= dmem_addr;
      last_wdata <= dmem_wdata;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) begin
      rom[i] = '0;
      ram[i] = '0;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    #1;
  endtask

  initial begin
    // 1: @5; D=A; then @0x11; M=D to expose D
    clear_mem();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0011; rom[3] = 16'hE308;
    reset = 1'b1;
    tick(2);
    check_eq("rst_imem_req", imem_req, 0);
    check_eq("rst_dmem_req", dmem_req, 0);
    check_eq("rst_pc", pc, 0);
    check_eq("rst_halted", halted, 0);
    reset = 1'b0;
    #1;
    check_eq("first_fetch_req", imem_req, 1);
    base_a = n_dreq;
    base_b = n_wr;
    tick(5);
    check_eq("t1_pc", pc, 2);
    check_eq("t1_no_dreq", n_dreq - base_a, 0);
    tick(6);
    check_eq("t1_wr_cnt", n_wr - base_b, 1);
    check_eq("t1_d_val", last_wdata, 16'h0005);
    check_eq("t1_wr_addr", last_waddr, 15'h0011);

    // 2: D=7 then M=D+1 at 0x0010
    clear_mem();
    rom[0] = 16'h0007; rom[1] = 16'hEC10; rom[2] = 16'h0010; rom[3] = 16'hE7C8;
    base_b = n_wr;
    do_reset();
    tick(10);
    check_eq("t2_dreq", dmem_req, 1);
    check_eq("t2_we", dmem_we, 1);
    check_eq("t2_addr", dmem_addr, 15'h0010);
    check_eq("t2_wdata", dmem_wdata, 16'h0008);
    check_eq("t2_pc", pc, 4);
    tick(1);
    check_eq("t2_wr_cnt", n_wr - base_b, 1);
    check_eq("t2_wr_data", last_wdata, 16'h0008);

    // 3: D=M with three read wait cycles, then M=D at 0x13
    clear_mem();
    rom[0] = 16'h0012; rom[1] = 16'hFC10; rom[2] = 16'h0013; rom[3] = 16'hE308;
    ram[8'h12] = 16'h1234;
    d_rd_wait = 3;
    base_b = n_wr;
    do_reset();
    tick(4);
    for (int k = 0; k < 4; k++) begin
      check_eq("t3_rd_req_held", dmem_req, 1);
      check_eq("t3_rd_addr_held", dmem_addr, 15'h0012);
      check_eq("t3_rd_we_low", dmem_we, 0);
      tick(1);
    end
    check_eq("t3_no_wr_during_rd", n_wr - base_b, 0);
    tick(10);
    check_eq("t3_wr_cnt", n_wr - base_b, 1);
    check_eq("t3_d_from_m", last_wdata, 16'h1234);
    check_eq("t3_wr_addr", last_waddr, 15'h0013);
    d_rd_wait = 0;

    // 4: JEQ taken with D=0, not taken with D=1, JLT taken with D=-1
    clear_mem();
    rom[8'h00] = 16'hEA90; rom[8'h01] = 16'h0020; rom[8'h02] = 16'hE302;
    rom[8'h20] = 16'hEFD0; rom[8'h21] = 16'h0030; rom[8'h22] = 16'hE302;
    rom[8'h23] = 16'hEE90; rom[8'h24] = 16'h0005; rom[8'h25] = 16'hE304;
    do_reset();
    tick(8);
    check_eq("t4_jeq_taken", pc, 15'h0020);
    tick(8);
    check_eq("t4_jeq_not_taken", pc, 15'h0023);
    tick(8);
    check_eq("t4_jlt_taken", pc, 15'h0005);
    check_eq("t4_fetch_addr", imem_addr, 15'h0005);

    // 5: AM=M+1 at 0x30 (M=4), then D=A; @0x31; M=D to expose new A
    clear_mem();
    rom[0] = 16'h0030; rom[1] = 16'hFDE8; rom[2] = 16'hEC10; rom[3] = 16'h0031; rom[4] = 16'hE308;
    ram[8'h30] = 16'h0004;
    base_b = n_wr;
    do_reset();
    tick(6);
    check_eq("t5_wr_req", dmem_req, 1);
    check_eq("t5_wr_we", dmem_we, 1);
    check_eq("t5_wr_addr_old_a", dmem_addr, 15'h0030);
    check_eq("t5_wr_data", dmem_wdata, 16'h0005);
    tick(1);
    check_eq("t5_wr_cnt", n_wr - base_b, 1);
    tick(9);
    check_eq("t5_new_a", last_wdata, 16'h0005);
    check_eq("t5_new_a_addr", last_waddr, 15'h0031);

    // 5b: reset while the M write is waiting for ack
    d_wr_wait = 3;
    base_b = n_wr;
    do_reset();
    tick(6);
    check_eq("t5b_in_mwrite", dmem_req, 1);
    tick(1);
    reset = 1'b1;
    #1;
    check_eq("t5b_rst_dreq", dmem_req, 0);
    tick(1);
    check_eq("t5b_rst_pc", pc, 0);
    check_eq("t5b_rst_ireq", imem_req, 0);
    reset = 1'b0;
    #1;
    check_eq("t5b_refetch_req", imem_req, 1);
    check_eq("t5b_refetch_addr", imem_addr, 0);
    tick(1);
    check_eq("t5b_no_write", n_wr - base_b, 0);
    d_wr_wait = 0;

    // 6: self-jump at pc=4 (A=4, 0;JMP)
    clear_mem();
    rom[3] = 16'h0004; rom[4] = 16'hEA87;
    do_reset();
    tick(11);
    check_eq("t6_pc", pc, 15'h0004);
`ifdef CPU_HALT_EN
    check_eq("t6_halted", halted, 1);
    base_a = n_ireq;
    base_b = n_dreq;
    tick(20);
    check_eq("t6_no_ireq", n_ireq - base_a, 0);
    check_eq("t6_no_dreq", n_dreq - base_b, 0);
    check_eq("t6_still_halted", halted, 1);
    check_eq("t6_pc_frozen", pc, 15'h0004);
`else
    check_eq("t6_halted_tied", halted, 0);
    check_eq("t6_refetch_req", imem_req, 1);
    check_eq("t6_refetch_addr", imem_addr, 15'h0004);
    base_a = n_fetch;
    base_b = n_dreq;
    tick(21);
    check_eq("t6_loop_fetches", n_fetch - base_a, 7);
    check_eq("t6_no_dreq", n_dreq - base_b, 0);
    check_eq("t6_pc_loop", pc, 15'h0004);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
